// File: rtl/painterengine_gpu_displayscan.sv
// Display scan sequencer: walks the clipped window of a texture in raster order and
// issues one 32-bit pixel byte address per handshake, with line/frame/done status.
module painterengine_gpu_displayscan (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_clip_valid,
    input  logic [15:0] i_wire_clip_width,
    input  logic [15:0] i_wire_clip_height,
    input  logic [15:0] i_wire_image_width,
    input  logic [31:0] i_wire_texture_address,
    input  logic        i_wire_frame_start,
    input  logic        i_wire_addr_ready,
    output logic [31:0] o_wire_addr,
    output logic        o_wire_addr_valid,
    output logic [15:0] o_wire_x,
    output logic [15:0] o_wire_y,
    output logic        o_wire_line_last,
    output logic        o_wire_frame_last,
    output logic        o_wire_busy,
    output logic        o_wire_done
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state_q;
    logic [15:0] width_q;
    logic [15:0] height_q;
    logic [15:0] stride_q;
    logic [15:0] x_q;
    logic [15:0] y_q;
    logic [31:0] addr_q;
    logic [31:0] rowBase_q;
    logic        valid_q;
    logic        lineLast_q;
    logic        frameLast_q;
    logic        busy_q;
    logic        done_q;

    logic [15:0] lastX_d;
    logic [15:0] lastY_d;
    logic [15:0] xNext_d;
    logic [15:0] yNext_d;
    logic [31:0] rowStep_d;
    logic [31:0] nextRowBase_d;
    logic        atLineEnd_d;
    logic        atFrameEnd_d;
    logic        accept_d;
    logic        startOk_d;
    logic        startEmpty_d;

    assign lastX_d       = width_q - 16'd1;
    assign lastY_d       = height_q - 16'd1;
    assign xNext_d       = x_q + 16'd1;
    assign yNext_d       = y_q + 16'd1;
    // Stride is in pixels; the row step in bytes is stride*4, zero-extended.
    assign rowStep_d     = {14'd0, stride_q, 2'b00};
    assign nextRowBase_d = rowBase_q + rowStep_d;
    assign atLineEnd_d   = (x_q == lastX_d);
    assign atFrameEnd_d  = (y_q == lastY_d);
    assign accept_d      = valid_q & i_wire_addr_ready;
    assign startOk_d     = i_wire_frame_start & i_wire_clip_valid;
    assign startEmpty_d  = (i_wire_clip_width == 16'd0) || (i_wire_clip_height == 16'd0);

    // Line/frame-last flags are computed for the position being loaded so they stay registered.
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q     <= IDLE;
            width_q     <= 16'd0;
            height_q    <= 16'd0;
            stride_q    <= 16'd0;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            addr_q      <= 32'd0;
            rowBase_q   <= 32'd0;
            valid_q     <= 1'b0;
            lineLast_q  <= 1'b0;
            frameLast_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (startOk_d) begin
                        width_q   <= i_wire_clip_width;
                        height_q  <= i_wire_clip_height;
                        stride_q  <= i_wire_image_width;
                        addr_q    <= i_wire_texture_address;
                        rowBase_q <= i_wire_texture_address;
                        x_q       <= 16'd0;
                        y_q       <= 16'd0;
                        busy_q    <= 1'b1;
                        if (startEmpty_d) begin
                            state_q     <= DONE;
                            valid_q     <= 1'b0;
                            lineLast_q  <= 1'b0;
                            frameLast_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state_q     <= SCAN;
                            valid_q     <= 1'b1;
                            lineLast_q  <= (i_wire_clip_width == 16'd1);
                            frameLast_q <= (i_wire_clip_width == 16'd1) &&
                                           (i_wire_clip_height == 16'd1);
                        end
                    end
                end
                SCAN: begin
                    if (accept_d) begin
                        if (!atLineEnd_d) begin
                            x_q         <= xNext_d;
                            addr_q      <= addr_q + 32'd4;
                            lineLast_q  <= (xNext_d == lastX_d);
                            frameLast_q <= (xNext_d == lastX_d) && atFrameEnd_d;
                        end else if (!atFrameEnd_d) begin
                            x_q         <= 16'd0;
                            y_q         <= yNext_d;
                            rowBase_q   <= nextRowBase_d;
                            addr_q      <= nextRowBase_d;
                            lineLast_q  <= (lastX_d == 16'd0);
                            frameLast_q <= (lastX_d == 16'd0) && (yNext_d == lastY_d);
                        end else begin
                            state_q     <= DONE;
                            valid_q     <= 1'b0;
                            lineLast_q  <= 1'b0;
                            frameLast_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    valid_q     <= 1'b0;
                    lineLast_q  <= 1'b0;
                    frameLast_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign o_wire_addr       = addr_q;
    assign o_wire_addr_valid = valid_q;
    assign o_wire_x          = x_q;
    assign o_wire_y          = y_q;
    assign o_wire_line_last  = lineLast_q;
    assign o_wire_frame_last = frameLast_q;
    assign o_wire_busy       = busy_q;
    assign o_wire_done       = done_q;

endmodule

// File: doc/painterengine_gpu_displayscan.md
# painterengine_gpu_displayscan

Display-side pixel fetch sequencer that consumes the clipped display size (clip width/height plus valid) and walks that window of the source texture in raster order. For each pixel it issues one 32-bit word read address on a valid/ready handshake toward the texture read port. It sits between display clipping and the texture memory reader, and reports line, frame and completion status to the video output path.

## Interface
- No parameters; pixel size fixed at 4 bytes (32-bit ARGB).
- i_wire_clock  input  1  sole clock
- i_wire_resetn  input  1  reset; asynchronous, active-low
- i_wire_clip_valid  input  1  clip width/height are valid
- i_wire_clip_width  input  16  pixels per displayed line
- i_wire_clip_height  input  16  displayed lines
- i_wire_image_width  input  16  texture stride in pixels
- i_wire_texture_address  input  32  byte address of texture pixel (0,0)
- i_wire_frame_start  input  1  single-cycle frame request
- i_wire_addr_ready  input  1  downstream accepts address
- o_wire_addr  output  32  pixel byte address
- o_wire_addr_valid  output  1  o_wire_addr is valid
- o_wire_x  output  16  column of current address
- o_wire_y  output  16  row of current address
- o_wire_line_last  output  1  current address is last of its line
- o_wire_frame_last  output  1  current address is last of frame
- o_wire_busy  output  1  frame in progress
- o_wire_done  output  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: accepts i_wire_frame_start only when i_wire_clip_valid=1. On acceptance it latches width W, height H, stride S and base B, then sets pixel address and row base to B and x=y=0.
  - If W=0 or H=0, it goes to DONE and issues no addresses.
  - Otherwise it goes to SCAN.
- A frame_start seen while clip_valid=0 is dropped.
- SCAN: o_wire_addr_valid=1. An address is accepted when addr_valid & addr_ready.
  - On accept with x<W-1: x+1, addr+4.
  - On accept with x=W-1 and y<H-1: x=0, y+1, row_base+=S*4, addr=new row_base.
  - On accept with x=W-1 and y=H-1: go to DONE.
- DONE: o_wire_done=1 for exactly one cycle, then IDLE.
- o_wire_busy=1 in SCAN and DONE.
- o_wire_line_last = valid & (x==W-1).
- o_wire_frame_last = line_last & (y==H-1).
- No multiplier. Row base is accumulated: S*4 is a 16-bit stride shifted left by 2, zero-extended to 32 bits. All address arithmetic is modulo 2^32, so wrap past 0xFFFFFFFC is silent.
- W larger than S is not checked; addresses are generated as specified.
- Inputs are latched only at frame acceptance. Changes during SCAN have no effect.
- i_wire_frame_start during SCAN or DONE is ignored and not queued.

## Timing
- Reset (async assert): state IDLE. o_wire_addr=0, o_wire_addr_valid=0, o_wire_x=0, o_wire_y=0, o_wire_line_last=0, o_wire_frame_last=0, o_wire_busy=0, o_wire_done=0. Deassertion is used synchronously.
- frame_start accepted at edge N: addr_valid=1 with addr=B from cycle N+1.
- With ready held high: one address per cycle, W*H consecutive cycles.
- Backpressure: while addr_valid & !addr_ready, addr/x/y/line_last/frame_last hold stable.
- Last accept at edge M: done=1 and addr_valid=0 during cycle M+1; IDLE from M+2, where a new frame_start can be accepted.
- Zero-size frame accepted at edge N: done=1 during N+1, no addr_valid.
- Reset mid-SCAN: all outputs go to reset values immediately and no done pulse is issued.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Basic raster: W=4, H=2, S=8, B=0x1000, ready=1.
  - Addresses are 0x1000, 0x1004, 0x1008, 0x100C, 0x1020, 0x1024, 0x1028, 0x102C on consecutive cycles.
  - line_last on the 4th and 8th addresses; frame_last on the 8th only.
  - done one cycle after the last accept.
- Backpressure: same frame with ready toggling 1,0,0,1,… → exactly 8 accepts, same address order, outputs stable during every ready=0 cycle, busy=1 throughout.
- Zero size: W=0, H=5, frame_start → done pulse at N+1, addr_valid never 1, back in IDLE at N+2.
- Gating: frame_start with clip_valid=0 → no activity. A second frame_start mid-SCAN, while also changing clip width → ignored; the original W*H count completes.
- Reset mid-frame: assert resetn=0 after 3 accepts → all outputs 0 asynchronously. After release, a new frame with W=2, H=1, B=0x20 yields 0x20, 0x24, then done.
- Wrap: W=3, H=1, B=0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, then done.
